// File: rtl/clk_rst_mgr.sv
// clk_rst_mgr: PLL lock qualification, sequenced system reset, lock-loss counter and fractional tick channels.
module clk_rst_mgr #(
  parameter int NCH = 2,
  parameter int ACC_W = 24,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD = 16,
  parameter int LOSS_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic [NCH*ACC_W-1:0] inc,
  input  logic [NCH-1:0]       tick_en,
  input  logic                 clr_loss,
  output logic                 sys_reset,
  output logic                 ready,
  output logic [NCH-1:0]       tick,
  output logic [LOSS_W-1:0]    loss_cnt
);
  localparam int CMAX = LOCK_STABLE > RST_HOLD ? LOCK_STABLE : RST_HOLD;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic sys_reset_q, sys_reset_d, ready_q, ready_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [ACC_W-1:0] acc_q [NCH];
  logic [ACC_W-1:0] acc_d [NCH];
  logic [ACC_W:0] sum [NCH];
  logic locked_s, run_en;
  assign locked_s = sync_q[1];
  // The first synchronised-lock cycle is counted on the WAIT_LOCK exit, so
  // sys_reset falls exactly LOCK_STABLE+RST_HOLD edges after locked_s rises.
  always_comb begin
    sync_d = {sync_q[0], pll_locked};
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        state_d = !locked_s ? WAIT_LOCK : (LOCK_STABLE == 1 ? HOLD : STABLE);
        cnt_d = (locked_s && LOCK_STABLE != 1) ? CW'(1) : '0;
      end
      STABLE: begin
        state_d = !locked_s ? WAIT_LOCK : (cnt_q == CW'(LOCK_STABLE - 1) ? HOLD : STABLE);
        cnt_d = (state_d == STABLE) ? cnt_q + CW'(1) : '0;
      end
      HOLD: begin
        state_d = !locked_s ? WAIT_LOCK : (cnt_q == CW'(RST_HOLD - 1) ? RUN : HOLD);
        cnt_d = (state_d == HOLD) ? cnt_q + CW'(1) : '0;
      end
      default: begin
        state_d = locked_s ? RUN : WAIT_LOCK;
        cnt_d = '0;
      end
    endcase
    loss_d = clr_loss ? '0 :
             (state_q == RUN && !locked_s && !(&loss_q)) ? loss_q + LOSS_W'(1) : loss_q;
    sys_reset_d = state_d != RUN;
    ready_d = state_d == RUN;
    for (int i = 0; i < NCH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc[i*ACC_W +: ACC_W]};
      run_en = state_q == RUN && tick_en[i];
      acc_d[i] = run_en ? sum[i][ACC_W-1:0] : '0;
      tick_d[i] = run_en & sum[i][ACC_W];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      sync_q <= '0;
      cnt_q <= '0;
      loss_q <= '0;
      sys_reset_q <= 1'b1;
      ready_q <= 1'b0;
      tick_q <= '0;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      loss_q <= loss_d;
      sys_reset_q <= sys_reset_d;
      ready_q <= ready_d;
      tick_q <= tick_d;
      for (int i = 0; i < NCH; i++) acc_q[i] <= acc_d[i];
    end
  end
  assign sys_reset = sys_reset_q;
  assign ready = ready_q;
  assign tick = tick_q;
  assign loss_cnt = loss_q;
endmodule

// File: tb/tb_clk_rst_mgr.sv
// tb_clk_rst_mgr: directed checks of lock qualification, loss counting and tick channels.
module tb_clk_rst_mgr;
  logic clk = 0, reset = 1, pll_locked = 0, clr_loss = 0;
  logic [15:0] inc = '0;
  logic [1:0] tick_en = '0, tick;
  logic sys_reset, ready;
  logic [1:0] loss_cnt;
  int n_run = 0, n_fail = 0;
  clk_rst_mgr #(.NCH(2), .ACC_W(8), .LOCK_STABLE(8), .RST_HOLD(4), .LOSS_W(2)) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .inc(inc), .tick_en(tick_en),
    .clr_loss(clr_loss), .sys_reset(sys_reset), .ready(ready), .tick(tick), .loss_cnt(loss_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic qualify(input string tag);
    for (int e = 1; e <= 14; e++) begin
      step();
      chk($sformatf("%s_sysrst_e%0d", tag, e), 32'(sys_reset), 32'(e < 14));
    end
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_tick"}, 32'(tick), 0);
  endtask
  task automatic drop(input string tag, input logic clr, input int exp_loss);
    pll_locked = 0;
    step();
    chk({tag, "_still_run"}, 32'(sys_reset), 0);
    step();
    clr_loss = clr;
    step();
    clr_loss = 0;
    chk({tag, "_sysrst"}, 32'(sys_reset), 1);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_loss"}, 32'(loss_cnt), 32'(exp_loss));
    pll_locked = 1;
    qualify(tag);
  endtask
  initial begin
    int c0, c1, first;
    step();
    step();
    chk("rst_sysrst", 32'(sys_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_loss", 32'(loss_cnt), 0);
    reset = 0;
    pll_locked = 1;
    qualify("t1");
    chk("t1_loss", 32'(loss_cnt), 0);
    reset = 1;
    pll_locked = 0;
    step();
    reset = 0;
    pll_locked = 1;
    repeat (7) step();
    pll_locked = 0;
    repeat (2) step();
    pll_locked = 1;
    qualify("t2");
    chk("t2_loss", 32'(loss_cnt), 0);
    for (int k = 1; k <= 3; k++) drop($sformatf("t3_drop%0d", k), 1'b0, k);
    clr_loss = 1;
    step();
    clr_loss = 0;
    chk("t3_clr", 32'(loss_cnt), 0);
    drop("t3_clr_vs_inc", 1'b1, 0);
    for (int k = 1; k <= 5; k++) drop($sformatf("t3_sat%0d", k), 1'b0, k > 3 ? 3 : k);
    inc = {8'd64, 8'd128};
    tick_en = 2'b11;
    c0 = 0;
    c1 = 0;
    for (int e = 1; e <= 64; e++) begin
      step();
      if (e <= 8) begin
        chk($sformatf("t4_tick0_e%0d", e), 32'(tick[0]), 32'(e % 2 == 0));
        chk($sformatf("t4_tick1_e%0d", e), 32'(tick[1]), 32'(e % 4 == 0));
      end
      c0 += int'(tick[0]);
      c1 += int'(tick[1]);
    end
    chk("t4_cnt0", 32'(c0), 32);
    chk("t4_cnt1", 32'(c1), 16);
    inc = {8'd0, 8'd128};
    c1 = 0;
    for (int e = 1; e <= 32; e++) begin
      step();
      c1 += int'(tick[1]);
    end
    chk("t4_inc0_cnt1", 32'(c1), 0);
    tick_en = 2'b00;
    step();
    inc = {8'd0, 8'd3};
    tick_en = 2'b01;
    c0 = 0;
    first = 0;
    for (int e = 1; e <= 256; e++) begin
      step();
      if (tick[0] && first == 0) first = e;
      c0 += int'(tick[0]);
    end
    chk("t5_cnt0", 32'(c0), 3);
    chk("t5_first", 32'(first), 86);
    tick_en = 2'b00;
    step();
    chk("t5_disable", 32'(tick[0]), 0);
    tick_en = 2'b01;
    first = 0;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (tick[0] && first == 0) first = e;
    end
    chk("t5_refirst", 32'(first), 86);
    inc = {8'd0, 8'd128};
    repeat (5) step();
    chk("t6_pre_loss", 32'(loss_cnt), 3);
    #3 reset = 1;
    #1;
    chk("t6_sysrst", 32'(sys_reset), 1);
    chk("t6_ready", 32'(ready), 0);
    chk("t6_tick", 32'(tick), 0);
    chk("t6_loss", 32'(loss_cnt), 0);
    #2 reset = 0;
    qualify("t6");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
